// File: rtl/cascade_stage_scheduler.sv
// Viola-Jones cascade sequencer for one detection window: fetches stage
// descriptors, streams feature addresses, and turns stage verdicts into a
// face / no-face result.
//
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   start_i, num_stages_i, abort_i  window control from the window controller
//   busy_o, done_o, result_o        window status; result held between windows
//   stage_idx_o                     current / last evaluated stage
//   desc_rd_o, desc_addr_o          stage descriptor read request
//   desc_val_i, desc_threshold_i,
//   desc_feat_cnt_i, desc_feat_base_i  stage descriptor return
//   stage_clr_o, stage_threshold_o,
//   stage_threshold_val_o, stage_last_o  stage accumulator / comparator control
//   feat_val_o, feat_addr_o,
//   feat_last_o, feat_rdy_i         feature request stream (valid/ready)
//   verdict_val_i, verdict_pass_i   stage comparator verdict
module cascade_stage_scheduler #(
  parameter int STAGE_W = 5,
  parameter int FEAT_W  = 12,
  parameter int ADDR_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [STAGE_W-1:0] num_stages_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               result_o,
  output logic [STAGE_W-1:0] stage_idx_o,
  output logic               desc_rd_o,
  output logic [STAGE_W-1:0] desc_addr_o,
  input  logic               desc_val_i,
  input  logic [31:0]        desc_threshold_i,
  input  logic [FEAT_W-1:0]  desc_feat_cnt_i,
  input  logic [ADDR_W-1:0]  desc_feat_base_i,
  output logic               stage_clr_o,
  output logic [31:0]        stage_threshold_o,
  output logic               stage_threshold_val_o,
  output logic               stage_last_o,
  output logic               feat_val_o,
  output logic [ADDR_W-1:0]  feat_addr_o,
  output logic               feat_last_o,
  input  logic               feat_rdy_i,
  input  logic               verdict_val_i,
  input  logic               verdict_pass_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [STAGE_W-1:0] nstg_q, nstg_d;
  logic [31:0]        thr_q, thr_d;
  logic [FEAT_W-1:0]  cnt_q, cnt_d;
  logic [FEAT_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               result_q, result_d;

  logic last_stage;
  logic last_feat;
  logic stage_pass;

  assign last_stage = (stage_q == nstg_q - STAGE_W'(1));
  assign last_feat  = (k_q == cnt_q - FEAT_W'(1));

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    nstg_d     = nstg_q;
    thr_d      = thr_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    base_d     = base_q;
    result_d   = result_q;
    stage_pass = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          nstg_d  = num_stages_i;
          stage_d = '0;
          if (num_stages_i == '0) begin
            // An empty cascade rejects nothing.
            result_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (desc_val_i) begin
          thr_d   = desc_threshold_i;
          cnt_d   = desc_feat_cnt_i;
          base_d  = desc_feat_base_i;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // A featureless stage passes without a verdict.
        if (cnt_q == '0) begin
          stage_pass = 1'b1;
        end else begin
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (feat_rdy_i) begin
          k_d = k_q + FEAT_W'(1);
          if (last_feat) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (verdict_val_i) begin
          if (verdict_pass_i) begin
            stage_pass = 1'b1;
          end else begin
            result_d = 1'b0;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stage_pass) begin
      if (last_stage) begin
        result_d = 1'b1;
        state_d  = S_DONE;
      end else begin
        stage_d = stage_q + STAGE_W'(1);
        state_d = S_FETCH;
      end
    end

    // Abort freezes everything except the return to IDLE.
    if (abort_i) begin
      state_d  = S_IDLE;
      stage_d  = stage_q;
      nstg_d   = nstg_q;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      nstg_q   <= '0;
      thr_q    <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      base_q   <= '0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      nstg_q   <= nstg_d;
      thr_q    <= thr_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      base_q   <= base_d;
      result_q <= result_d;
    end
  end

  assign busy_o                = (state_q != S_IDLE);
  assign done_o                = (state_q == S_DONE);
  assign result_o              = result_q;
  assign stage_idx_o           = stage_q;
  assign desc_rd_o             = (state_q == S_FETCH);
  assign desc_addr_o           = stage_q;
  assign stage_clr_o           = (state_q == S_LOAD);
  assign stage_threshold_val_o = (state_q == S_LOAD);
  assign stage_threshold_o     = thr_q;
  assign stage_last_o          = busy_o && last_stage;
  assign feat_val_o            = (state_q == S_ISSUE);
  assign feat_addr_o           = base_q + ADDR_W'(k_q);
  assign feat_last_o           = feat_val_o && last_feat;

endmodule

// File: tb/tb_cascade_stage_scheduler.sv
// Scoreboard bench for cascade_stage_scheduler: directed windows from the
// test plan, abort/reset cases, then randomized windows with spurious inputs.
module tb_cascade_stage_scheduler;

  localparam int SW = 5;
  localparam int FW = 12;
  localparam int AW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [SW-1:0] num_stages_i = '0;
  logic          abort_i = 1'b0;
  logic          desc_val_i = 1'b0;
  logic [31:0]   desc_threshold_i = '0;
  logic [FW-1:0] desc_feat_cnt_i = '0;
  logic [AW-1:0] desc_feat_base_i = '0;
  logic          feat_rdy_i = 1'b0;
  logic          verdict_val_i = 1'b0;
  logic          verdict_pass_i = 1'b0;

  logic          busy_o, done_o, result_o;
  logic [SW-1:0] stage_idx_o, desc_addr_o;
  logic          desc_rd_o, stage_clr_o;
  logic [31:0]   stage_threshold_o;
  logic          stage_threshold_val_o, stage_last_o;
  logic          feat_val_o, feat_last_o;
  logic [AW-1:0] feat_addr_o;

  cascade_stage_scheduler #(
    .STAGE_W(SW), .FEAT_W(FW), .ADDR_W(AW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .start_i(start_i), .num_stages_i(num_stages_i),
    .abort_i(abort_i), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o),
    .stage_idx_o(stage_idx_o),
    .desc_rd_o(desc_rd_o), .desc_addr_o(desc_addr_o),
    .desc_val_i(desc_val_i),
    .desc_threshold_i(desc_threshold_i),
    .desc_feat_cnt_i(desc_feat_cnt_i),
    .desc_feat_base_i(desc_feat_base_i),
    .stage_clr_o(stage_clr_o),
    .stage_threshold_o(stage_threshold_o),
    .stage_threshold_val_o(stage_threshold_val_o),
    .stage_last_o(stage_last_o),
    .feat_val_o(feat_val_o), .feat_addr_o(feat_addr_o),
    .feat_last_o(feat_last_o), .feat_rdy_i(feat_rdy_i),
    .verdict_val_i(verdict_val_i),
    .verdict_pass_i(verdict_pass_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          last;
    logic          slast;
  } feat_t;

  typedef struct packed {
    logic          res;
    logic [SW-1:0] stg;
  } done_t;

  feat_t       exp_feat[$];
  done_t       exp_done[$];
  logic [31:0] exp_thr[$];

  int          cnt_tbl[32];
  int          base_tbl[32];
  bit          pass_tbl[32];
  logic [31:0] thr_tbl[32];

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  bit sb_on = 1'b1;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: walk the cascade using the descriptor tables.
  task automatic model(input int n, output int nf);
    nf = 0;
    if (n == 0) begin
      exp_done.push_back(done_t'{res: 1'b1, stg: '0});
      return;
    end
    for (int s = 0; s < n; s++) begin
      nf++;
      exp_thr.push_back(thr_tbl[s]);
      for (int k = 0; k < cnt_tbl[s]; k++)
        exp_feat.push_back(feat_t'{addr: AW'(base_tbl[s] + k),
                                   last: (k == cnt_tbl[s] - 1),
                                   slast: (s == n - 1)});
      if (cnt_tbl[s] != 0 && !pass_tbl[s]) begin
        exp_done.push_back(done_t'{res: 1'b0, stg: SW'(s)});
        return;
      end
      if (s == n - 1)
        exp_done.push_back(done_t'{res: 1'b1, stg: SW'(s)});
    end
  endtask

  // Monitor: sample mid-cycle and pop expectations.
  logic          stall_p = 1'b0;
  logic [AW-1:0] stall_addr = '0;
  logic          stall_last = 1'b0;

  always @(negedge clk_i) begin : mon
    feat_t f;
    done_t d;
    logic [31:0] t;
    if (!rst_ni) begin
      stall_p = 1'b0;
    end else begin
      if (done_o) begin
        done_cnt++;
        if (sb_on) begin
          if (exp_done.size() == 0) begin
            chk(1'b0, "unexpected_done", 32'(stage_idx_o), 0);
          end else begin
            d = exp_done.pop_front();
            chk(result_o == d.res, "done_result", 32'(result_o), 32'(d.res));
            chk(stage_idx_o == d.stg, "done_stage", 32'(stage_idx_o), 32'(d.stg));
          end
        end
      end
      if (sb_on && stage_threshold_val_o) begin
        if (exp_thr.size() == 0) begin
          chk(1'b0, "unexpected_load", stage_threshold_o, 0);
        end else begin
          t = exp_thr.pop_front();
          chk(stage_threshold_o == t, "threshold", stage_threshold_o, t);
          chk(stage_clr_o == 1'b1, "clr_with_thr", 32'(stage_clr_o), 1);
        end
      end
      if (stall_p)
        chk(feat_val_o && feat_addr_o == stall_addr && feat_last_o == stall_last,
            "stall_hold", 32'(feat_addr_o), 32'(stall_addr));
      if (sb_on && feat_val_o && feat_rdy_i) begin
        if (exp_feat.size() == 0) begin
          chk(1'b0, "unexpected_feat", 32'(feat_addr_o), 0);
        end else begin
          f = exp_feat.pop_front();
          chk(feat_addr_o == f.addr, "feat_addr", 32'(feat_addr_o), 32'(f.addr));
          chk(feat_last_o == f.last, "feat_last", 32'(feat_last_o), 32'(f.last));
          chk(stage_last_o == f.slast, "stage_last", 32'(stage_last_o), 32'(f.slast));
        end
      end
      stall_p    = sb_on && feat_val_o && !feat_rdy_i;
      stall_addr = feat_addr_o;
      stall_last = feat_last_o;
    end
  end

  bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // rdy_mode: 0 always ready, 1 random, 2 fixed toggle pattern.
  // vdelay < 0 picks a random verdict delay.
  task automatic run_window(input int n, input int rdy_mode, input int vdelay,
                            input bit spur, input int lat);
    int  exp_fetch, fetches, ncyc, vcnt, pidx;
    bit  fin, pend_last, fetch_p, verd_p;
    model(n, exp_fetch);
    fetches = 0; ncyc = 0; vcnt = -1; pidx = 0;
    fin = 0; pend_last = 0; fetch_p = 0; verd_p = 0;
    start_i = 1'b1;
    num_stages_i = SW'(n);
    cyc();
    start_i = 1'b0;
    chk(desc_rd_o == (n != 0), "start_to_fetch", 32'(desc_rd_o), 32'(n != 0));
    chk(done_o == (n == 0), "start_to_done", 32'(done_o), 32'(n == 0));
    while (!fin && ncyc < 3000) begin
      if (fetch_p) begin
        fetches++;
        chk(stage_clr_o, "load_latency", 32'(stage_clr_o), 1);
      end
      if (verd_p)
        chk(done_o || desc_rd_o, "verdict_latency", 32'(done_o), 1);
      if (pend_last) vcnt = (vdelay < 0) ? int'($urandom_range(0, 4)) : vdelay;
      if (done_o) begin
        fin = 1'b1;
      end else begin
        desc_val_i = desc_rd_o && ($urandom_range(0, lat) == 0);
        desc_threshold_i = thr_tbl[desc_addr_o];
        desc_feat_cnt_i = FW'(cnt_tbl[desc_addr_o]);
        desc_feat_base_i = AW'(base_tbl[desc_addr_o]);
        if (rdy_mode == 0) feat_rdy_i = 1'b1;
        else if (rdy_mode == 1) feat_rdy_i = 1'($urandom);
        else begin
          feat_rdy_i = pat[pidx % 6];
          if (feat_val_o) pidx++;
        end
        verdict_val_i = 1'b0;
        verd_p = 1'b0;
        if (vcnt == 0) begin
          verdict_val_i = 1'b1;
          verdict_pass_i = pass_tbl[stage_idx_o];
          verd_p = 1'b1;
          vcnt = -1;
        end else if (vcnt > 0) begin
          vcnt--;
        end else if (spur && feat_val_o && $urandom_range(0, 3) == 0) begin
          verdict_val_i = 1'b1;
          verdict_pass_i = 1'($urandom);
        end
        start_i = spur && busy_o && ($urandom_range(0, 3) == 0);
        num_stages_i = SW'($urandom);
        pend_last = feat_val_o && feat_last_o && feat_rdy_i;
        fetch_p = desc_rd_o && desc_val_i;
        cyc();
        ncyc++;
      end
    end
    start_i = 0; desc_val_i = 0; feat_rdy_i = 0; verdict_val_i = 0;
    chk(fin, "window_timeout", 32'(ncyc), 3000);
    chk(fetches == exp_fetch, "fetch_count", 32'(fetches), 32'(exp_fetch));
    cyc();
    chk(!busy_o, "idle_after_done", 32'(busy_o), 0);
    chk(exp_feat.size() == 0 && exp_done.size() == 0 && exp_thr.size() == 0,
        "queues_drained", 32'(exp_feat.size() + exp_done.size()), 0);
  endtask

  // Drive a window by hand until features start streaming.
  task automatic reach_issue(input int n, output bit ok);
    ok = 1'b0;
    start_i = 1'b1;
    num_stages_i = SW'(n);
    cyc();
    start_i = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (feat_val_o) begin
        ok = 1'b1;
      end else begin
        desc_val_i = desc_rd_o;
        desc_threshold_i = thr_tbl[desc_addr_o];
        desc_feat_cnt_i = FW'(cnt_tbl[desc_addr_o]);
        desc_feat_base_i = AW'(base_tbl[desc_addr_o]);
        cyc();
      end
    end
    desc_val_i = 1'b0;
  endtask

  task automatic set_stage(input int s, input int c, input int b, input bit p);
    cnt_tbl[s] = c;
    base_tbl[s] = b;
    pass_tbl[s] = p;
    thr_tbl[s] = $urandom;
  endtask

  initial begin : main
    bit ok;
    logic prev_res;
    int dc0;
    for (int s = 0; s < 32; s++) set_stage(s, 1, 0, 1'b1);

    cyc();
    cyc();
    chk({busy_o, done_o, result_o, desc_rd_o, stage_clr_o,
         stage_threshold_val_o, feat_val_o, feat_last_o, stage_last_o} == '0,
        "reset_flags", 32'({busy_o, done_o, result_o, desc_rd_o}), 0);
    chk(stage_threshold_o == 0 && stage_idx_o == 0, "reset_regs",
        stage_threshold_o, 0);
    rst_ni = 1'b1;
    cyc();

    set_stage(0, 3, 16'h0010, 1'b1);
    set_stage(1, 2, 16'h0040, 1'b1);
    run_window(2, 0, 4, 1'b0, 0);

    set_stage(0, 2, 16'h0100, 1'b0);
    set_stage(1, 3, 16'h0200, 1'b1);
    set_stage(2, 1, 16'h0300, 1'b1);
    run_window(3, 0, 2, 1'b0, 1);

    set_stage(0, 6, 16'h0123, 1'b1);
    run_window(1, 2, 1, 1'b0, 0);

    set_stage(0, 2, 16'h0500, 1'b1);
    set_stage(1, 0, 16'h0600, 1'b0);
    set_stage(2, 1, 16'h0700, 1'b1);
    run_window(3, 0, 0, 1'b0, 0);

    set_stage(0, 3, 16'hFFFE, 1'b1);
    run_window(1, 1, 3, 1'b0, 0);

    run_window(0, 0, 0, 1'b0, 0);

    // Abort mid-stream: back to IDLE, no done, result kept.
    sb_on = 1'b0;
    set_stage(0, 5, 16'h0800, 1'b1);
    set_stage(1, 2, 16'h0900, 1'b1);
    prev_res = result_o;
    dc0 = done_cnt;
    feat_rdy_i = 1'b1;
    reach_issue(2, ok);
    chk(ok, "abort_reach_issue", 32'(ok), 1);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    feat_rdy_i = 1'b0;
    chk(!busy_o && !feat_val_o, "abort_idle", 32'(busy_o), 0);
    chk(result_o == prev_res, "abort_result_kept", 32'(result_o), 32'(prev_res));
    repeat (4) cyc();
    chk(done_cnt == dc0, "abort_no_done", 32'(done_cnt), 32'(dc0));

    // Async reset while waiting for the verdict.
    set_stage(0, 1, 16'h0A00, 1'b1);
    reach_issue(1, ok);
    feat_rdy_i = 1'b1;
    cyc();
    feat_rdy_i = 1'b0;
    chk(ok && busy_o && !feat_val_o, "reach_wait", 32'(busy_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk({busy_o, done_o, result_o, desc_rd_o, stage_clr_o, feat_val_o,
         stage_last_o} == '0 && stage_threshold_o == 0,
        "async_reset", 32'({busy_o, result_o, stage_last_o}), 0);
    cyc();
    rst_ni = 1'b1;
    cyc();
    sb_on = 1'b1;

    for (int w = 0; w < 40; w++) begin
      for (int s = 0; s < 6; s++)
        set_stage(s, $urandom_range(0, 5), $urandom_range(0, 65535),
                  ($urandom_range(0, 4) != 0));
      run_window($urandom_range(0, 5), 1, -1, 1'b1, 2);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
